sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/arb_cycle_counter.sv | 28 ++
 rtl/sdram_port_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and width defaults for the SDRAM port arbiter
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_HOLD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_cycle_counter.sv
// rtl/arb_cycle_counter.sv - per-transaction cycle counter with rollover flag
module arb_cycle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] rollover_val,
  output logic             rollover_flag
);

  logic [CNT_W-1:0] r_count;

  // Flag marks the rollover_val-th enabled cycle since the last clear.
  assign rollover_flag = count_enable && (r_count == (rollover_val - CNT_W'(1)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      r_count <= rollover_flag ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port read/write arbiter in front of a simple SDRAM controller
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_TIMEOUT = 255,
  parameter int WR_HOLD    = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  output logic              wr_done,
  output logic              sdram_read_en,
  output logic              sdram_write_en,
  output logic [ADDR_W-1:0] address_sdram,
  output logic [DATA_W-1:0] writeData_sdram,
  input  logic [DATA_W-1:0] data_sdram,
  input  logic              sdram_datareadvalid,
  output logic              timeout_err,
  input  logic              clear_err
);

  localparam int MAX_CNT = (RD_TIMEOUT > WR_HOLD) ? RD_TIMEOUT : WR_HOLD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_last_was_wr;
  logic              r_rd_grant;
  logic              r_wr_grant;
  logic              r_rd_valid;
  logic              r_timeout_err;
  logic              w_idle;
  logic              w_accept_rd;
  logic              w_accept_wr;
  logic              w_roll;
  logic              w_rd_done;
  logic              w_timeout;
  logic [CNT_W-1:0]  w_roll_val;

  assign w_idle = (r_state == ST_IDLE);

  // On a tie the requester that was not served last wins.
  assign w_accept_wr = w_idle && wr_req && (!rd_req || !r_last_was_wr);
  assign w_accept_rd = w_idle && rd_req && (!wr_req || r_last_was_wr);

  assign w_roll_val = (r_state == ST_RD_WAIT) ? CNT_W'(RD_TIMEOUT) : CNT_W'(WR_HOLD);

  arb_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cycle_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (w_idle),
    .count_enable (!w_idle),
    .rollover_val (w_roll_val),
    .rollover_flag(w_roll)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    sdram_read_en   = 1'b0;
    sdram_write_en  = 1'b0;
    address_sdram   = '0;
    writeData_sdram = '0;
    wr_done         = 1'b0;
    w_rd_done       = 1'b0;
    w_timeout       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_wr) begin
          w_next_state = ST_WR_HOLD;
        end else if (w_accept_rd) begin
          w_next_state = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        sdram_read_en = 1'b1;
        address_sdram = r_addr;
        // Returned data beats a timeout landing in the same cycle.
        w_rd_done     = sdram_datareadvalid || w_roll;
        w_timeout     = w_roll && !sdram_datareadvalid;
        if (w_rd_done) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WR_HOLD: begin
        sdram_write_en  = 1'b1;
        address_sdram   = r_addr;
        writeData_sdram = r_wdata;
        wr_done         = w_roll;
        if (w_roll) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rd_data     <= '0;
      r_last_was_wr <= 1'b0;
      r_rd_grant    <= 1'b0;
      r_wr_grant    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rd_grant <= w_accept_rd;
      r_wr_grant <= w_accept_wr;
      r_rd_valid <= w_rd_done;
      if (w_accept_wr) begin
        r_addr        <= wr_addr;
        r_wdata       <= wr_data;
        r_last_was_wr <= 1'b1;
      end else if (w_accept_rd) begin
        r_addr        <= rd_addr;
        r_last_was_wr <= 1'b0;
      end
      if ((r_state == ST_RD_WAIT) && sdram_datareadvalid) begin
        r_rd_data <= data_sdram;
      end else if (w_timeout) begin
        r_rd_data <= '0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (clear_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign rd_grant    = r_rd_grant;
  assign wr_grant    = r_wr_grant;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign timeout_err = r_timeout_err;

endmodule
